// File: rtl/receptor_palabras_uart.sv
// Rebuilds MSB-first 32-bit words from the UART byte stream and presents them on valid/ready,
// with an inter-byte timeout, an overflow flag and a delivered-word counter.
module receptor_palabras_uart #(
  parameter int unsigned WIDTH_WORD           = 8,
  parameter int unsigned LONGITUD_INSTRUCCION = 32,
  parameter int unsigned TIMEOUT_CICLOS       = 1000000,
  parameter int unsigned CANT_BITS_CONTADOR   = 10
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_soft_reset,
  input  logic                            i_rx_done,
  input  logic [WIDTH_WORD-1:0]           i_data_rx,
  input  logic                            i_ready,
  output logic [LONGITUD_INSTRUCCION-1:0] o_dato,
  output logic                            o_valid,
  output logic [CANT_BITS_CONTADOR-1:0]   o_cuenta,
  output logic [1:0]                      o_bytes_pendientes,
  output logic                            o_error_timeout,
  output logic                            o_error_overflow
);

  localparam int unsigned SHIFT_W = LONGITUD_INSTRUCCION - WIDTH_WORD;
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT_CICLOS + 1);

  logic [SHIFT_W-1:0]              parcial;
  logic [IDLE_W-1:0]               idle;
  logic [LONGITUD_INSTRUCCION-1:0] palabra;
  logic                            completa;
  logic                            transfer;
  logic                            expira;

  // The first three bytes sit in parcial; the fourth is appended straight from the input.
  assign palabra  = {parcial, i_data_rx};
  assign completa = i_rx_done && (o_bytes_pendientes == 2'd3);
  assign transfer = o_valid && i_ready;
  // A byte arriving in the expiry cycle wins, so expiry requires no rx_done.
  assign expira   = !i_rx_done && (o_bytes_pendientes != 2'd0) &&
                    (idle == IDLE_W'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      parcial            <= '0;
      idle               <= '0;
      o_dato             <= '0;
      o_valid            <= 1'b0;
      o_cuenta           <= '0;
      o_bytes_pendientes <= 2'd0;
      o_error_timeout    <= 1'b0;
      o_error_overflow   <= 1'b0;
    end else if (!i_soft_reset) begin
      parcial            <= '0;
      idle               <= '0;
      o_dato             <= '0;
      o_valid            <= 1'b0;
      o_cuenta           <= '0;
      o_bytes_pendientes <= 2'd0;
      o_error_timeout    <= 1'b0;
      o_error_overflow   <= 1'b0;
    end else begin
      // Byte assembly and inter-byte timeout
      if (i_rx_done) begin
        idle               <= '0;
        o_bytes_pendientes <= o_bytes_pendientes + 2'd1;
        parcial            <= {parcial[SHIFT_W-WIDTH_WORD-1:0], i_data_rx};
      end else if (expira) begin
        idle               <= '0;
        o_bytes_pendientes <= 2'd0;
        o_error_timeout    <= 1'b1;
      end else if (o_bytes_pendientes != 2'd0) begin
        idle <= idle + IDLE_W'(1);
      end

      if (transfer) begin
        o_cuenta <= o_cuenta + CANT_BITS_CONTADOR'(1);
      end

      // Output holding register: a completion replaces the word only if it is free or leaving now
      if (completa && (!o_valid || i_ready)) begin
        o_dato  <= palabra;
        o_valid <= 1'b1;
      end else begin
        if (completa) begin
          o_error_overflow <= 1'b1;
        end
        if (transfer) begin
          o_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_receptor_palabras_uart.sv
// Self-checking bench for receptor_palabras_uart: delivered words are checked against a
// scoreboard queue, counters and flags are checked inline by each scenario task.
module tb_receptor_palabras_uart;

  localparam int unsigned WW = 8;
  localparam int unsigned LI = 32;
  localparam int unsigned TO = 16;
  localparam int unsigned CB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          soft_n = 1'b1;
  logic          rx_done = 1'b0;
  logic [WW-1:0] data_rx = '0;
  logic          ready = 1'b0;
  logic [LI-1:0] dato;
  logic          valid;
  logic [CB-1:0] cuenta;
  logic [1:0]    pend;
  logic          err_to;
  logic          err_ov;

  int n_cmp = 0;
  int n_err = 0;
  logic [LI-1:0] sb[$];

  receptor_palabras_uart #(
    .WIDTH_WORD(WW), .LONGITUD_INSTRUCCION(LI),
    .TIMEOUT_CICLOS(TO), .CANT_BITS_CONTADOR(CB)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_soft_reset(soft_n),
    .i_rx_done(rx_done), .i_data_rx(data_rx), .i_ready(ready),
    .o_dato(dato), .o_valid(valid), .o_cuenta(cuenta),
    .o_bytes_pendientes(pend), .o_error_timeout(err_to), .o_error_overflow(err_ov)
  );

  always #5 clk = ~clk;

  // Scoreboard: a word about to be accepted at the next edge must match the queue head.
  always @(negedge clk) begin
    if (rst_n && soft_n && valid && ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL delivered_word: got %08h, expected none queued", dato);
      end else begin
        logic [LI-1:0] exp_w;
        exp_w = sb.pop_front();
        if (dato !== exp_w) begin
          n_err++;
          $display("FAIL delivered_word: got %08h, expected %08h", dato, exp_w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [WW-1:0] b);
    rx_done = 1'b1;
    data_rx = b;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [LI-1:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({dato, valid, cuenta, pend, err_to, err_ov} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got dato=%08h v=%b c=%0d p=%0d to=%b ov=%b, expected all 0",
               dato, valid, cuenta, pend, err_to, err_ov);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_word();
    logic [WW-1:0] bytes [4];
    bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    hard_reset();
    ready = 1'b1;
    sb.push_back(32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i]);
      n_cmp++;
      if (pend !== 2'((i + 1) % 4)) begin
        n_err++;
        $display("FAIL basic_pend: got %0d, expected %0d", pend, (i + 1) % 4);
      end
    end
    n_cmp++;
    if (valid !== 1'b1 || dato !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL basic_word: got v=%b dato=%08h, expected v=1 dato=deadbeef", valid, dato);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b0 || cuenta !== 2'd1) begin
      n_err++;
      $display("FAIL basic_after: got v=%b cuenta=%0d, expected v=0 cuenta=1", valid, cuenta);
    end
  endtask

  task automatic test_overflow();
    hard_reset();
    ready = 1'b0;
    sb.push_back(32'h11223344);
    send_word(32'h11223344);
    send_word(32'h55667788);
    n_cmp++;
    if (dato !== 32'h11223344 || valid !== 1'b1 || err_ov !== 1'b1 || cuenta !== 2'd0) begin
      n_err++;
      $display("FAIL overflow_hold: got dato=%08h v=%b ov=%b c=%0d, expected 11223344 1 1 0",
               dato, valid, err_ov, cuenta);
    end
    ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (valid !== 1'b0 || cuenta !== 2'd1 || err_ov !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_drain: got v=%b c=%0d ov=%b, expected 0 1 1", valid, cuenta, err_ov);
    end
  endtask

  task automatic test_simultaneous();
    hard_reset();
    ready = 1'b0;
    sb.push_back(32'h0A0B0C0D);
    send_word(32'h0A0B0C0D);
    send_byte(8'h1B);
    send_byte(8'h2B);
    send_byte(8'h3B);
    ready = 1'b1;
    sb.push_back(32'h1B2B3B4B);
    send_byte(8'h4B);
    n_cmp++;
    if (valid !== 1'b1 || dato !== 32'h1B2B3B4B || cuenta !== 2'd1 || err_ov !== 1'b0) begin
      n_err++;
      $display("FAIL simultaneous: got v=%b dato=%08h c=%0d ov=%b, expected 1 1b2b3b4b 1 0",
               valid, dato, cuenta, err_ov);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b0 || cuenta !== 2'd2) begin
      n_err++;
      $display("FAIL simultaneous_drain: got v=%b c=%0d, expected 0 2", valid, cuenta);
    end
  endtask

  task automatic test_timeout();
    hard_reset();
    ready = 1'b1;
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TO - 1) tick();
    n_cmp++;
    if (pend !== 2'd2 || err_to !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: got p=%0d to=%b, expected 2 0", pend, err_to);
    end
    tick();
    n_cmp++;
    if (pend !== 2'd0 || err_to !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_fire: got p=%0d to=%b, expected 0 1", pend, err_to);
    end
    sb.push_back(32'h01020304);
    send_word(32'h01020304);
    n_cmp++;
    if (dato !== 32'h01020304 || valid !== 1'b1 || err_to !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_next: got dato=%08h v=%b to=%b, expected 01020304 1 1", dato, valid, err_to);
    end
    tick();
  endtask

  task automatic test_timeout_race();
    hard_reset();
    ready = 1'b1;
    send_byte(8'h55);
    repeat (TO - 1) tick();
    send_byte(8'h66);
    n_cmp++;
    if (pend !== 2'd2 || err_to !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_race: got p=%0d to=%b, expected 2 0", pend, err_to);
    end
  endtask

  task automatic test_reset_midword();
    // Leaves err_to and cuenta non-zero so the clears are observable.
    hard_reset();
    ready = 1'b1;
    send_byte(8'h99);
    repeat (TO) tick();
    sb.push_back(32'h12345678);
    send_word(32'h12345678);
    tick();
    send_byte(8'h77);
    send_byte(8'h88);
    rst_n = 1'b0;
    sb.delete();
    #1;
    n_cmp++;
    if ({dato, valid, cuenta, pend, err_to, err_ov} !== '0) begin
      n_err++;
      $display("FAIL hard_reset_mid: got dato=%08h v=%b c=%0d p=%0d to=%b, expected all 0",
               dato, valid, cuenta, pend, err_to);
    end
    tick();
    rst_n = 1'b1;
    tick();
    sb.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    n_cmp++;
    if (dato !== 32'hCAFEF00D || valid !== 1'b1) begin
      n_err++;
      $display("FAIL hard_reset_after: got dato=%08h v=%b, expected cafef00d 1", dato, valid);
    end
    tick();
    send_byte(8'h77);
    send_byte(8'h88);
    soft_n  = 1'b0;
    rx_done = 1'b1;
    data_rx = 8'hEE;
    tick();
    soft_n  = 1'b1;
    rx_done = 1'b0;
    n_cmp++;
    if ({dato, valid, cuenta, pend, err_to, err_ov} !== '0) begin
      n_err++;
      $display("FAIL soft_reset_mid: got dato=%08h v=%b c=%0d p=%0d to=%b, expected all 0",
               dato, valid, cuenta, pend, err_to);
    end
    sb.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    n_cmp++;
    if (dato !== 32'hCAFEF00D || valid !== 1'b1) begin
      n_err++;
      $display("FAIL soft_reset_after: got dato=%08h v=%b, expected cafef00d 1", dato, valid);
    end
    tick();
  endtask

  task automatic test_counter_wrap();
    hard_reset();
    ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      logic [LI-1:0] w;
      w = LI'($urandom);
      sb.push_back(w);
      send_word(w);
      tick();
      n_cmp++;
      if (cuenta !== CB'(k % 4)) begin
        n_err++;
        $display("FAIL counter_wrap: word %0d got cuenta=%0d, expected %0d", k, cuenta, k % 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_overflow();
    test_simultaneous();
    test_timeout();
    test_timeout_race();
    test_reset_midword();
    test_counter_wrap();
    tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d words undelivered, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
